pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Sequencer for the 5-stage F/D/E/M/W RV32I pipeline, which has no forwarding
//  and writes the register file in W. Tracks in-flight destination registers in
//  its own E/M/W scoreboard and stalls F/D on read-after-write hazards.
//  Squashes wrong-path work when a jump or taken branch resolves in M. Drains
//  and halts the pipeline on EBREAK. Counts stall cycles for performance tuning.
// PARAMETERS
//  REG_W   5    register-id width
//  CNT_W   32   stall-cycle counter width
// PORTS
//  clk           in   1      clock; all state updates on posedge
//  resetn        in   1      reset, asynchronous, active-low
//  D_valid       in   1      FD holds a real instruction
//  D_rs1Id       in   REG_W  rs1 of the instruction in D
//  D_rs2Id       in   REG_W  rs2 of the instruction in D
//  D_usesRs1     in   1      instruction in D reads rs1
//  D_usesRs2     in   1      instruction in D reads rs2
//  D_rdId        in   REG_W  rd of the instruction in D
//  D_writesRd    in   1      instruction in D writes rd
//  D_isEBREAK    in   1      instruction in D is EBREAK
//  M_jumpOrBranch in  1      instruction in M redirects the PC this cycle
//  resume        in   1      single-cycle pulse; leaves HALTED
//  F_stall       out  1      hold F_PC and FD
//  D_stall       out  1      hold FD; insert a bubble into DE
//  FD_flush      out  1      FD instruction is invalid next cycle
//  DE_flush      out  1      DE instruction becomes a bubble (no wb, no store)
//  halted        out  1      pipeline is stopped on EBREAK
//  stall_cycles  out  CNT_W  saturating count of D_stall cycles
// BEHAVIOUR
//  - Scoreboard: sbE/sbM/sbW, each {v, rd}. Every cycle: sbW<=sbM;
//    sbM<= DE_flush ? 0 : sbE;
//    sbE<= (D_stall|FD_flush|!D_valid) ? 0 : {D_writesRd & D_rdId!=0, D_rdId}.
//  - hazard = D_valid & ((D_usesRs1 & rs1!=0 & rs1 hits any valid sb entry) |
//    (same test for rs2)). W is included because the write lands at the end of W.
//  - Priority, combinational:
//    1. M_jumpOrBranch -> FD_flush=1, DE_flush=1, D_stall=0, F_stall=0
//       (F loads the target).
//    2. hazard -> D_stall=1, F_stall=1.
//    3. otherwise all outputs 0, except as the FSM overrides them.
//  - FSM states RUN, DRAIN, HALTED; 2-bit drain counter dcnt.
//    - RUN: D_valid & D_isEBREAK & !hazard & !M_jumpOrBranch -> DRAIN, dcnt<=0.
//      This cycle F_stall=1.
//    - DRAIN: F_stall=1, FD_flush=1. Each cycle dcnt++.
//      - M_jumpOrBranch -> RUN: EBREAK was wrong-path; rule 1 applies this cycle.
//      - dcnt==2 with no redirect -> HALTED: E, M and W have been emptied.
//    - HALTED: halted=1, F_stall=1, FD_flush=1; the scoreboard is empty.
//      resume -> RUN next cycle. resume in RUN or DRAIN is ignored.
//  - Latency: a hazard with rd in E stalls 3 cycles; rd in M, 2; rd in W, 1.
//    EBREAK accept to halted=1 takes exactly 4 cycles.
//  - stall_cycles increments on each D_stall cycle and holds at 2^CNT_W-1.
//  - Reset (async, including mid-operation):
//    - state=RUN, dcnt=0, scoreboard empty, stall_cycles=0;
//    - hence F_stall=D_stall=FD_flush=DE_flush=halted=0 while resetn=0
//      (D_valid is forced to 0 by the datapath).
//  - x0 never creates a hazard or a scoreboard entry.
// STRUCTURE
//  - pipeline_pkg: state enum {RUN, DRAIN, HALTED}, DRAIN_CYCLES=3,
//    REG_ZERO=5'd0, sb_entry_t struct {logic v; logic [4:0] rd;}.
//  - One sub-module, hazard_scoreboard: the 3-entry shift register plus the
//    rs1/rs2 match logic; outputs hazard.
//  - FSM, priority mux and counter live in the top module.
// TESTING
//  1. add x5 in D, then D: add x6,x5,x1 -> D_stall=1 for 3 cycles, 4th cycle
//     issues; stall_cycles=3.
//  2. addi x0,x0,1 followed by a reader of x0 -> no stall; sbE.v=0.
//  3. Hazard on x7 in D while M_jumpOrBranch=1 -> FD_flush=DE_flush=1,
//     D_stall=0; sbM cleared next cycle.
//  4. EBREAK in D with an older add/sw/lw in flight -> DRAIN for 3 cycles,
//     halted=1 on cycle 4; resume pulse -> halted=0 and F_stall=0 next cycle.
//  5. EBREAK accepted, then M_jumpOrBranch=1 one cycle later -> state RUN,
//     halted stays 0.
//  6. Assert resetn=0 mid-stall, asynchronously -> all outputs 0 immediately,
//     stall_cycles=0; preload 2^CNT_W-2 with CNT_W=4 -> counter sticks at 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the F/D/E/M/W hazard sequencer: FSM states, scoreboard entry, register-id constants.
// No logic beyond a pure match helper.
package pipeline_hazard_ctrl_pkg;

  localparam int REG_ID_W     = 5;
  localparam int DRAIN_CYCLES = 3;
  localparam logic [REG_ID_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } ctrl_state_e;

  typedef struct packed {
    logic                v;
    logic [REG_ID_W-1:0] rd;
  } sb_entry_t;

  function automatic logic sb_hit(input sb_entry_t e, input logic [REG_ID_W-1:0] rs);
    return e.v && (e.rd == rs);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_scoreboard.sv
// E/M/W destination-register scoreboard and rs1/rs2 RAW match; hazard is combinational from flops.
// One entry shifts per cycle; stalled or flushed D slots enter as empty entries.
module pipeline_hazard_ctrl_scoreboard
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  logic                d_valid,
  input  logic [REG_ID_W-1:0] rs1_id,
  input  logic [REG_ID_W-1:0] rs2_id,
  input  logic                uses_rs1,
  input  logic                uses_rs2,
  input  logic [REG_ID_W-1:0] rd_id,
  input  logic                writes_rd,
  input  logic                d_stall,
  input  logic                fd_flush,
  input  logic                de_flush,
  output logic                hazard
);

  sb_entry_t sb_e_q, sb_e_d;
  sb_entry_t sb_m_q, sb_m_d;
  sb_entry_t sb_w_q, sb_w_d;
  logic      rs1_hit, rs2_hit;

  always_comb begin
    sb_e_d = '0;
    if (d_valid && !d_stall && !fd_flush) begin
      sb_e_d.v  = writes_rd && (rd_id != REG_ZERO);
      sb_e_d.rd = rd_id;
    end
    sb_m_d = de_flush ? '0 : sb_e_q;
    sb_w_d = sb_m_q;
  end

  // W still counts: the register file is written at the end of W, with no bypass.
  always_comb begin
    rs1_hit = uses_rs1 && (rs1_id != REG_ZERO) &&
              (sb_hit(sb_e_q, rs1_id) || sb_hit(sb_m_q, rs1_id) || sb_hit(sb_w_q, rs1_id));
    rs2_hit = uses_rs2 && (rs2_id != REG_ZERO) &&
              (sb_hit(sb_e_q, rs2_id) || sb_hit(sb_m_q, rs2_id) || sb_hit(sb_w_q, rs2_id));
    hazard  = d_valid && (rs1_hit || rs2_hit);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sb_e_q <= '0;
      sb_m_q <= '0;
      sb_w_q <= '0;
    end else begin
      sb_e_q <= sb_e_d;
      sb_m_q <= sb_m_d;
      sb_w_q <= sb_w_d;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/halt sequencer for the 5-stage pipeline; stall and flush outputs are combinational.
// RAW stalls hold F/D for 1-3 cycles; EBREAK drains E/M/W and halts 4 cycles after acceptance.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             D_valid,
  input  logic [REG_W-1:0] D_rs1Id,
  input  logic [REG_W-1:0] D_rs2Id,
  input  logic             D_usesRs1,
  input  logic             D_usesRs2,
  input  logic [REG_W-1:0] D_rdId,
  input  logic             D_writesRd,
  input  logic             D_isEBREAK,
  input  logic             M_jumpOrBranch,
  input  logic             resume,
  output logic             F_stall,
  output logic             D_stall,
  output logic             FD_flush,
  output logic             DE_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles
);

  ctrl_state_e      state_q, state_d;
  logic [1:0]       dcnt_q, dcnt_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic             hazard;
  logic             ebreak_go;

  pipeline_hazard_ctrl_scoreboard u_sb (
    .clk       (clk),
    .resetn    (resetn),
    .d_valid   (D_valid),
    .rs1_id    (D_rs1Id),
    .rs2_id    (D_rs2Id),
    .uses_rs1  (D_usesRs1),
    .uses_rs2  (D_usesRs2),
    .rd_id     (D_rdId),
    .writes_rd (D_writesRd),
    .d_stall   (D_stall),
    .fd_flush  (FD_flush),
    .de_flush  (DE_flush),
    .hazard    (hazard)
  );

  // A redirect from M outranks everything, including a DRAIN already in progress.
  always_comb begin
    F_stall   = 1'b0;
    D_stall   = 1'b0;
    FD_flush  = 1'b0;
    DE_flush  = 1'b0;
    ebreak_go = (state_q == RUN) && D_valid && D_isEBREAK && !hazard && !M_jumpOrBranch;
    if (M_jumpOrBranch) begin
      FD_flush = 1'b1;
      DE_flush = 1'b1;
    end else if (hazard) begin
      D_stall = 1'b1;
      F_stall = 1'b1;
    end
    if (ebreak_go) F_stall = 1'b1;
    if ((state_q == DRAIN && !M_jumpOrBranch) || state_q == HALTED) begin
      F_stall  = 1'b1;
      FD_flush = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      RUN: begin
        if (ebreak_go) begin
          state_d = DRAIN;
          dcnt_d  = 2'd0;
        end
      end
      DRAIN: begin
        dcnt_d = dcnt_q + 2'd1;
        if (M_jumpOrBranch)                        state_d = RUN;
        else if (dcnt_q == 2'(DRAIN_CYCLES - 1))   state_d = HALTED;
      end
      HALTED: begin
        if (resume) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    halted_d = (state_d == HALTED);

    stall_cycles_d = stall_cycles_q;
    if (D_stall && (stall_cycles_q != {CNT_W{1'b1}}))
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= RUN;
      dcnt_q         <= 2'd0;
      halted_q       <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      dcnt_q         <= dcnt_d;
      halted_q       <= halted_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign halted       = halted_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized + directed bench for pipeline_hazard_ctrl against an age-window behavioural model.
// Two instances share stimulus: 32-bit and 4-bit stall counters.
module tb_pipeline_hazard_ctrl;

  logic        clk;
  logic        resetn;
  logic        D_valid, D_usesRs1, D_usesRs2, D_writesRd, D_isEBREAK;
  logic [4:0]  D_rs1Id, D_rs2Id, D_rdId;
  logic        M_jumpOrBranch, resume;

  logic        F_stall, D_stall, FD_flush, DE_flush, halted;
  logic [31:0] stall_cycles;
  logic        F_stall4, D_stall4, FD_flush4, DE_flush4, halted4;
  logic [3:0]  stall_cycles4;

  int checks   = 0;
  int failures = 0;

  pipeline_hazard_ctrl #(.REG_W(5), .CNT_W(32)) u_dut (
    .clk(clk), .resetn(resetn), .D_valid(D_valid), .D_rs1Id(D_rs1Id), .D_rs2Id(D_rs2Id),
    .D_usesRs1(D_usesRs1), .D_usesRs2(D_usesRs2), .D_rdId(D_rdId), .D_writesRd(D_writesRd),
    .D_isEBREAK(D_isEBREAK), .M_jumpOrBranch(M_jumpOrBranch), .resume(resume),
    .F_stall(F_stall), .D_stall(D_stall), .FD_flush(FD_flush), .DE_flush(DE_flush),
    .halted(halted), .stall_cycles(stall_cycles)
  );

  pipeline_hazard_ctrl #(.REG_W(5), .CNT_W(4)) u_dut4 (
    .clk(clk), .resetn(resetn), .D_valid(D_valid), .D_rs1Id(D_rs1Id), .D_rs2Id(D_rs2Id),
    .D_usesRs1(D_usesRs1), .D_usesRs2(D_usesRs2), .D_rdId(D_rdId), .D_writesRd(D_writesRd),
    .D_isEBREAK(D_isEBREAK), .M_jumpOrBranch(M_jumpOrBranch), .resume(resume),
    .F_stall(F_stall4), .D_stall(D_stall4), .FD_flush(FD_flush4), .DE_flush(DE_flush4),
    .halted(halted4), .stall_cycles(stall_cycles4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: each issued writer remembers its issue cycle; a register is busy for the
  // three cycles after issue unless the writer was squashed while in E.
  typedef struct {int t; int rd; bit killed;} wr_t;
  wr_t     pend[$];
  int      cyc;
  bit      m_halted, m_draining;
  int      accept_cyc;
  longint  m_stalls;

  function automatic bit busy(input logic [4:0] rs);
    if (rs == 5'd0) return 1'b0;
    foreach (pend[i])
      if (!pend[i].killed && pend[i].t >= cyc - 3 && pend[i].rd == int'(rs)) return 1'b1;
    return 1'b0;
  endfunction

  always @(negedge clk) begin : cmp
    bit redir, hz, acc;
    bit e_f, e_d, e_fd, e_de;
    longint e_s4;
    if (!resetn) begin
      cyc = 0; m_halted = 0; m_draining = 0; m_stalls = 0; accept_cyc = -100;
      pend.delete();
      chk("rst_F_stall",  64'(F_stall),  64'd0);
      chk("rst_D_stall",  64'(D_stall),  64'd0);
      chk("rst_FD_flush", 64'(FD_flush), 64'd0);
      chk("rst_DE_flush", 64'(DE_flush), 64'd0);
      chk("rst_halted",   64'(halted),   64'd0);
      chk("rst_stall_cycles", 64'(stall_cycles), 64'd0);
    end else begin
      redir = M_jumpOrBranch;
      hz    = D_valid && ((D_usesRs1 && busy(D_rs1Id)) || (D_usesRs2 && busy(D_rs2Id)));
      acc   = !m_halted && !m_draining && D_valid && D_isEBREAK && !hz && !redir;
      e_fd  = redir;
      e_de  = redir;
      e_d   = !redir && hz;
      e_f   = e_d || acc;
      if ((m_draining && !redir) || m_halted) begin
        e_f  = 1'b1;
        e_fd = 1'b1;
      end
      e_s4 = (m_stalls > 15) ? 15 : m_stalls;
      chk("F_stall",  64'(F_stall),  64'(e_f));
      chk("D_stall",  64'(D_stall),  64'(e_d));
      chk("FD_flush", 64'(FD_flush), 64'(e_fd));
      chk("DE_flush", 64'(DE_flush), 64'(e_de));
      chk("halted",   64'(halted),   64'(m_halted));
      chk("stall_cycles",  64'(stall_cycles),  64'(m_stalls));
      chk("F_stall_w4",    64'(F_stall4),      64'(e_f));
      chk("D_stall_w4",    64'(D_stall4),      64'(e_d));
      chk("halted_w4",     64'(halted4),       64'(m_halted));
      chk("stall_cycles_w4", 64'(stall_cycles4), 64'(e_s4));
      // commit this cycle
      if (e_de)
        foreach (pend[i]) if (pend[i].t == cyc - 1) pend[i].killed = 1'b1;
      if (D_valid && !e_d && !e_fd && D_writesRd && D_rdId != 5'd0)
        pend.push_back('{t: cyc, rd: int'(D_rdId), killed: 1'b0});
      if (e_d) m_stalls++;
      if (m_halted) begin
        if (resume) m_halted = 1'b0;
      end else if (m_draining) begin
        if (redir) m_draining = 1'b0;
        else if (cyc - accept_cyc == 3) begin
          m_draining = 1'b0;
          m_halted   = 1'b1;
        end
      end else if (acc) begin
        m_draining = 1'b1;
        accept_cyc = cyc;
      end
      cyc++;
      while (pend.size() > 0 && pend[0].t < cyc - 3) void'(pend.pop_front());
    end
  end

  task automatic set_in(input bit v, input logic [4:0] rs1, input bit u1, input logic [4:0] rs2,
                        input bit u2, input logic [4:0] rd, input bit wr, input bit eb,
                        input bit m, input bit rsm);
    D_valid = v; D_rs1Id = rs1; D_usesRs1 = u1; D_rs2Id = rs2; D_usesRs2 = u2;
    D_rdId = rd; D_writesRd = wr; D_isEBREAK = eb; M_jumpOrBranch = m; resume = rsm;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_n(input int n);
    idle();
    repeat (n) tick();
  endtask

  initial begin
    resetn = 1'b1;
    idle();
    #1 resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    // 1: add x5 then add x6,x5,x1 -> three stall cycles, issues on the fourth
    set_in(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); #2;
    chk("t1_writer_no_stall", 64'(D_stall), 64'd0);
    tick();
    set_in(1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("t1_stall", 64'(D_stall), 64'd1);
      chk("t1_fstall", 64'(F_stall), 64'd1);
      tick();
    end
    #2;
    chk("t1_issue", 64'(D_stall), 64'd0);
    chk("t1_count", 64'(stall_cycles), 64'd3);
    idle_n(5);

    // 2: addi x0,x0,1 then a reader of x0
    set_in(1, 0, 1, 0, 0, 0, 1, 0, 0, 0); #2;
    chk("t2_no_stall_a", 64'(D_stall), 64'd0);
    tick();
    set_in(1, 0, 1, 0, 1, 3, 1, 0, 0, 0); #2;
    chk("t2_no_stall_b", 64'(D_stall), 64'd0);
    chk("t2_sbE_empty", 64'(u_dut.u_sb.sb_e_q.v), 64'd0);
    idle_n(5);

    // 3: hazard on x7 coincides with a redirect from M
    set_in(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    tick();
    set_in(1, 7, 1, 0, 0, 8, 1, 0, 1, 0); #2;
    chk("t3_fd_flush", 64'(FD_flush), 64'd1);
    chk("t3_de_flush", 64'(DE_flush), 64'd1);
    chk("t3_d_stall",  64'(D_stall),  64'd0);
    chk("t3_f_stall",  64'(F_stall),  64'd0);
    tick();
    set_in(1, 7, 1, 0, 0, 0, 0, 0, 0, 0); #2;
    chk("t3_sbM_cleared", 64'(u_dut.u_sb.sb_m_q.v), 64'd0);
    chk("t3_x7_free",     64'(D_stall), 64'd0);
    idle_n(5);

    // 4: EBREAK behind an add -> drain, halt on the 4th cycle, resume
    set_in(1, 0, 0, 0, 0, 9, 1, 0, 0, 0);
    tick();
    set_in(1, 0, 0, 0, 0, 0, 0, 1, 0, 0); #2;
    chk("t4_accept_fstall", 64'(F_stall), 64'd1);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("t4_drain_halted", 64'(halted), 64'd0);
      chk("t4_drain_fd_flush", 64'(FD_flush), 64'd1);
      tick();
    end
    #2;
    chk("t4_halted", 64'(halted), 64'd1);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); #2;
    chk("t4_still_halted", 64'(halted), 64'd1);
    tick();
    idle(); #2;
    chk("t4_resumed", 64'(halted), 64'd0);
    chk("t4_resumed_fstall", 64'(F_stall), 64'd0);
    idle_n(3);

    // 5: EBREAK accepted, redirect one cycle later cancels the drain
    set_in(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); #2;
    chk("t5_redirect_fstall", 64'(F_stall), 64'd0);
    tick();
    idle();
    for (int i = 0; i < 5; i++) begin
      #2;
      chk("t5_not_halted", 64'(halted), 64'd0);
      chk("t5_fstall_free", 64'(F_stall), 64'd0);
      tick();
    end

    // 6: asynchronous reset in the middle of a stall, then counter saturation
    set_in(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    tick();
    set_in(1, 5, 1, 0, 0, 0, 0, 0, 0, 0); #2;
    chk("t6_pre_stall", 64'(D_stall), 64'd1);
    #1 resetn = 1'b0;
    #1;
    chk("t6_rst_dstall", 64'(D_stall), 64'd0);
    chk("t6_rst_fstall", 64'(F_stall), 64'd0);
    chk("t6_rst_count",  64'(stall_cycles), 64'd0);
    chk("t6_rst_halted", 64'(halted), 64'd0);
    idle();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      set_in(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
      tick();
      set_in(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
      repeat (4) tick();
      idle_n(3);
    end
    #2;
    chk("t6_count32", 64'(stall_cycles), 64'd18);
    chk("t6_count4_sat", 64'(stall_cycles4), 64'd15);
    tick();

    // random phase
    for (int n = 0; n < 3000; n++) begin
      if (m_halted || m_draining) begin
        set_in(0, 0, 0, 0, 0, 0, 0, 0,
               m_draining && ($urandom_range(5) == 0), $urandom_range(5) == 0);
      end else begin
        set_in($urandom_range(3) != 0, 5'($urandom_range(7)), 1'($urandom),
               5'($urandom_range(7)), 1'($urandom), 5'($urandom_range(7)), 1'($urandom),
               $urandom_range(29) == 0, $urandom_range(11) == 0, $urandom_range(7) == 0);
      end
      tick();
    end

    idle();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
